// File: rtl/tl_sched_pkg.sv
// Shared types and constants for the intersection phase scheduler.
// Build option TL_SCHED_FLASH_EN adds the flashing-yellow state.
package tl_sched_pkg;

    localparam int unsigned DEF_MIN_GREEN = 5;
    localparam int unsigned DEF_MAX_GREEN = 20;
    localparam int unsigned DEF_YELLOW    = 3;
    localparam int unsigned DEF_ALL_RED   = 1;
    localparam int unsigned DEF_WALK      = 6;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_H_GREEN,
        ST_H_YELLOW,
        ST_V_GREEN,
        ST_V_YELLOW,
        ST_PED_WALK,
        ST_CLEAR
`ifdef TL_SCHED_FLASH_EN
        ,
        ST_FLASH
`endif
    } tl_state_e;

    // Lamp vectors are ordered {hr, hy, hg, vr, vy, vg}.
    localparam logic [5:0] LAMP_ALL_RED  = 6'b100_100;
    localparam logic [5:0] LAMP_H_GREEN  = 6'b001_100;
    localparam logic [5:0] LAMP_H_YELLOW = 6'b010_100;
    localparam logic [5:0] LAMP_V_GREEN  = 6'b100_001;
    localparam logic [5:0] LAMP_V_YELLOW = 6'b100_010;

    typedef enum logic [1:0] {
        REQ_H = 2'd0,
        REQ_V = 2'd1,
        REQ_P = 2'd2
    } req_id_e;

    typedef struct packed {
        tl_state_e state;
        logic      pend_h;
        logic      pend_v;
        logic      pend_p;
        req_id_e   last_served;
    } tl_dbg_t;

    function automatic req_id_e rot_next(input req_id_e id);
        case (id)
            REQ_H:   rot_next = REQ_V;
            REQ_V:   rot_next = REQ_P;
            default: rot_next = REQ_H;
        endcase
    endfunction

    // Round-robin pick starting after 'last'; H is the fallback when nobody waits.
    function automatic req_id_e next_grant(input req_id_e last, input logic [2:0] pend);
        req_id_e cand;
        req_id_e pick;
        logic    found;
        cand  = last;
        pick  = REQ_H;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cand = rot_next(cand);
            if (!found && pend[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        next_grant = pick;
    endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// 8-bit load/decrement interval timer; done marks the last cycle of an interval.
module tl_phase_timer #(
    parameter logic [7:0] RST_VAL = 8'd1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] count,
    output logic       done
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign done = (count == 8'd1);

endmodule

// File: rtl/tl_phase_scheduler.sv
// Round-robin phase scheduler for two vehicle approaches and a pedestrian walk.
// Define TL_SCHED_FLASH_EN to add the flash input and flashing-yellow state.
module tl_phase_scheduler
    import tl_sched_pkg::*;
#(
    parameter int unsigned T_MIN_GREEN = DEF_MIN_GREEN,
    parameter int unsigned T_MAX_GREEN = DEF_MAX_GREEN,
    parameter int unsigned T_YELLOW    = DEF_YELLOW,
    parameter int unsigned T_ALL_RED   = DEF_ALL_RED,
    parameter int unsigned T_WALK      = DEF_WALK
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       req_h,
    input  logic       req_v,
    input  logic       ped_req,
`ifdef TL_SCHED_FLASH_EN
    input  logic       flash,
`endif
    output logic       hr,
    output logic       hy,
    output logic       hg,
    output logic       vr,
    output logic       vy,
    output logic       vg,
    output logic       walk,
    output logic [7:0] count,
    output tl_dbg_t    dbg
);

    localparam logic [7:0] MIN_G   = 8'(T_MIN_GREEN);
    localparam logic [7:0] MAX_G   = 8'(T_MAX_GREEN);
    localparam logic [7:0] YEL_T   = 8'(T_YELLOW);
    localparam logic [7:0] RED_T   = 8'(T_ALL_RED);
    localparam logic [7:0] WALK_T  = 8'(T_WALK);

    tl_state_e   state, state_n;
    logic        pend_h, pend_v, pend_p;
    logic        pend_h_n, pend_v_n, pend_p_n;
    logic        raw_h, raw_v, raw_p;
    req_id_e     last_served, last_n, grant;
    logic [7:0]  green_el;
    logic [8:0]  green_lasted;
    logic        own_req, comp_now, comp_reg, green_end;
    logic        t_load, t_done;
    logic [7:0]  t_val, t_count;
    logic [5:0]  lamps;
`ifdef TL_SCHED_FLASH_EN
    logic        flash_ph;
`endif

    tl_phase_timer #(
        .RST_VAL (RED_T)
    ) u_timer (
        .clk      (clk),
        .clr      (clr),
        .load     (t_load),
        .load_val (t_val),
        .count    (t_count),
        .done     (t_done)
    );

    // Demand including this cycle's inputs; a requester is never latched while it holds the grant.
    always_comb begin
        raw_h = pend_h | (req_h   & (state != ST_H_GREEN));
        raw_v = pend_v | (req_v   & (state != ST_V_GREEN));
        raw_p = pend_p | (ped_req & (state != ST_PED_WALK));
    end

    assign grant        = next_grant(last_served, {raw_p, raw_v, raw_h});
    assign green_lasted = {1'b0, green_el} + 9'd1;

    always_comb begin
        own_req  = 1'b0;
        comp_now = 1'b0;
        comp_reg = 1'b0;
        case (state)
            ST_H_GREEN: begin
                own_req  = req_h;
                comp_now = raw_v | raw_p;
                comp_reg = pend_v | pend_p;
            end
            ST_V_GREEN: begin
                own_req  = req_v;
                comp_now = raw_h | raw_p;
                comp_reg = pend_h | pend_p;
            end
            default: ;
        endcase
        green_end = (green_lasted >= 9'(T_MIN_GREEN)) && comp_now &&
                    (!own_req || (green_lasted >= 9'(T_MAX_GREEN)));
    end

    always_comb begin
        state_n = state;
        last_n  = last_served;
        t_load  = 1'b0;
        t_val   = 8'd0;
        case (state)
            ST_INIT, ST_CLEAR: begin
                if (t_done) begin
                    t_load = 1'b1;
                    last_n = grant;
                    case (grant)
                        REQ_V: state_n = ST_V_GREEN;
                        REQ_P: begin
                            state_n = ST_PED_WALK;
                            t_val   = WALK_T;
                        end
                        default: state_n = ST_H_GREEN;
                    endcase
                end
            end
            ST_H_GREEN: begin
                if (green_end) begin
                    state_n = ST_H_YELLOW;
                    t_load  = 1'b1;
                    t_val   = YEL_T;
                end
            end
            ST_V_GREEN: begin
                if (green_end) begin
                    state_n = ST_V_YELLOW;
                    t_load  = 1'b1;
                    t_val   = YEL_T;
                end
            end
            ST_H_YELLOW, ST_V_YELLOW, ST_PED_WALK: begin
                if (t_done) begin
                    state_n = ST_CLEAR;
                    t_load  = 1'b1;
                    t_val   = RED_T;
                end
            end
`ifdef TL_SCHED_FLASH_EN
            ST_FLASH: begin
                if (!flash) begin
                    state_n = ST_CLEAR;
                    t_load  = 1'b1;
                    t_val   = RED_T;
                end
            end
`endif
            default: begin
                state_n = ST_INIT;
                t_load  = 1'b1;
                t_val   = RED_T;
            end
        endcase
`ifdef TL_SCHED_FLASH_EN
        // Flash pre-empts everything except the power-up all-red, and cancels any grant.
        if (flash && (state != ST_INIT) && (state != ST_FLASH)) begin
            state_n = ST_FLASH;
            last_n  = last_served;
            t_load  = 1'b1;
            t_val   = 8'd0;
        end
`endif
    end

    always_comb begin
        pend_h_n = raw_h & ~((state_n == ST_H_GREEN)  && (state != ST_H_GREEN));
        pend_v_n = raw_v & ~((state_n == ST_V_GREEN)  && (state != ST_V_GREEN));
        pend_p_n = raw_p & ~((state_n == ST_PED_WALK) && (state != ST_PED_WALK));
`ifdef TL_SCHED_FLASH_EN
        if (state == ST_FLASH) begin
            pend_h_n = 1'b0;
            pend_v_n = 1'b0;
            pend_p_n = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= ST_INIT;
            pend_h      <= 1'b0;
            pend_v      <= 1'b0;
            pend_p      <= 1'b0;
            last_served <= REQ_P;
            green_el    <= 8'd0;
        end else begin
            state       <= state_n;
            pend_h      <= pend_h_n;
            pend_v      <= pend_v_n;
            pend_p      <= pend_p_n;
            last_served <= last_n;
            if (state_n != state) begin
                green_el <= 8'd0;
            end else if (green_el != 8'hFF) begin
                green_el <= green_el + 8'd1;
            end
        end
    end

`ifdef TL_SCHED_FLASH_EN
    always_ff @(posedge clk) begin
        if (clr || (state != ST_FLASH)) begin
            flash_ph <= 1'b1;
        end else begin
            flash_ph <= ~flash_ph;
        end
    end
`endif

    always_comb begin
        case (state)
            ST_H_GREEN:  lamps = LAMP_H_GREEN;
            ST_H_YELLOW: lamps = LAMP_H_YELLOW;
            ST_V_GREEN:  lamps = LAMP_V_GREEN;
            ST_V_YELLOW: lamps = LAMP_V_YELLOW;
`ifdef TL_SCHED_FLASH_EN
            ST_FLASH:    lamps = {1'b0, flash_ph, 1'b0, 1'b0, flash_ph, 1'b0};
`endif
            default:     lamps = LAMP_ALL_RED;
        endcase
    end

    assign {hr, hy, hg, vr, vy, vg} = lamps;
    assign walk = (state == ST_PED_WALK);

    // Green has no loaded interval: show min-green remaining, then max-green remaining under demand.
    always_comb begin
        count = t_count;
        if ((state == ST_H_GREEN) || (state == ST_V_GREEN)) begin
            if (green_el < MIN_G) begin
                count = MIN_G - green_el;
            end else if (comp_reg && (green_el < MAX_G)) begin
                count = MAX_G - green_el;
            end else begin
                count = 8'd0;
            end
        end
`ifdef TL_SCHED_FLASH_EN
        if (state == ST_FLASH) begin
            count = 8'd0;
        end
`endif
    end

    always_comb begin
        dbg.state       = state;
        dbg.pend_h      = pend_h;
        dbg.pend_v      = pend_v;
        dbg.pend_p      = pend_p;
        dbg.last_served = last_served;
    end

endmodule

// File: tb/tb_tl_phase_scheduler.sv
// Self-checking bench for tl_phase_scheduler: directed scenarios plus random traffic
// against a cycle-level reference model of the phase rules.
module tb_tl_phase_scheduler;
    import tl_sched_pkg::*;

    localparam int T_MIN  = 5;
    localparam int T_MAX  = 20;
    localparam int T_Y    = 3;
    localparam int T_AR   = 1;
    localparam int T_WK   = 6;
`ifdef TL_SCHED_FLASH_EN
    localparam bit FLASH_EN = 1'b1;
`else
    localparam bit FLASH_EN = 1'b0;
`endif

    // Observed vector bit positions in {hr,hy,hg,vr,vy,vg,walk}
    localparam int L_WALK = 0;
    localparam int L_VG   = 1;
    localparam int L_VY   = 2;
    localparam int L_VR   = 3;
    localparam int L_HG   = 4;
    localparam int L_HY   = 5;
    localparam int L_HR   = 6;

    localparam int M_INIT = 0, M_HG = 1, M_HY = 2, M_VG = 3, M_VY = 4, M_WALK = 5, M_CLEAR = 6, M_FLASH = 7;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr = 1'b1, req_h = 1'b0, req_v = 1'b0, ped_req = 1'b0, flash = 1'b0;
    logic       hr, hy, hg, vr, vy, vg, walk;
    logic [7:0] count;
    tl_dbg_t    dbg;

    tl_phase_scheduler #(
        .T_MIN_GREEN (T_MIN),
        .T_MAX_GREEN (T_MAX),
        .T_YELLOW    (T_Y),
        .T_ALL_RED   (T_AR),
        .T_WALK      (T_WK)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .req_h   (req_h),
        .req_v   (req_v),
        .ped_req (ped_req),
`ifdef TL_SCHED_FLASH_EN
        .flash   (flash),
`endif
        .hr      (hr),
        .hy      (hy),
        .hg      (hg),
        .vr      (vr),
        .vy      (vy),
        .vg      (vg),
        .walk    (walk),
        .count   (count),
        .dbg     (dbg)
    );

    int vectors = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    int m_ph, m_rem, m_el, m_last;
    bit m_pend[3];
    bit m_fl;

    function automatic void model_reset();
        m_ph   = M_INIT;
        m_rem  = T_AR;
        m_el   = 0;
        m_last = 2;
        m_pend = '{1'b0, 1'b0, 1'b0};
        m_fl   = 1'b1;
    endfunction

    function automatic int model_pick();
        for (int k = 1; k <= 3; k++) begin
            if (m_pend[(m_last + k) % 3]) return (m_last + k) % 3;
        end
        return 0;
    endfunction

    function automatic void model_enter(input int g);
        m_ph = (g == 0) ? M_HG : (g == 1) ? M_VG : M_WALK;
        m_el = 0;
        if (g == 2) m_rem = T_WK;
        m_pend[g] = 1'b0;
        m_last = g;
    endfunction

    function automatic void model_step(input bit h, input bit v, input bit p, input bit f, input bit c);
        bit rq[3];
        bit np[3];
        int gr, own;
        bit comp;
        if (c) begin
            model_reset();
            return;
        end
        rq = '{h, v, p};
        gr = (m_ph == M_HG) ? 0 : (m_ph == M_VG) ? 1 : (m_ph == M_WALK) ? 2 : -1;
        for (int i = 0; i < 3; i++) np[i] = m_pend[i] || (rq[i] && gr != i);
        if (FLASH_EN && f && m_ph != M_INIT && m_ph != M_FLASH) begin
            m_ph = M_FLASH;
            m_fl = 1'b1;
            m_pend = np;
            return;
        end
        if (m_ph == M_FLASH) begin
            m_pend = '{1'b0, 1'b0, 1'b0};
            if (f) m_fl = !m_fl;
            else begin
                m_ph = M_CLEAR;
                m_rem = T_AR;
            end
            return;
        end
        m_pend = np;
        case (m_ph)
            M_INIT, M_CLEAR: begin
                if (m_rem == 1) model_enter(model_pick());
                else m_rem--;
            end
            M_HG, M_VG: begin
                own  = (m_ph == M_HG) ? 0 : 1;
                comp = np[1 - own] || np[2];
                if (m_el + 1 >= T_MIN && comp && (!rq[own] || m_el + 1 >= T_MAX)) begin
                    m_ph  = (own == 0) ? M_HY : M_VY;
                    m_rem = T_Y;
                end else if (m_el < 255) begin
                    m_el++;
                end
            end
            default: begin
                if (m_rem == 1) begin
                    m_ph = M_CLEAR;
                    m_rem = T_AR;
                end else m_rem--;
            end
        endcase
    endfunction

    function automatic logic [6:0] model_lamps();
        case (m_ph)
            M_HG:    return 7'b001_100_0;
            M_HY:    return 7'b010_100_0;
            M_VG:    return 7'b100_001_0;
            M_VY:    return 7'b100_010_0;
            M_WALK:  return 7'b100_100_1;
            M_FLASH: return {1'b0, m_fl, 1'b0, 1'b0, m_fl, 1'b0, 1'b0};
            default: return 7'b100_100_0;
        endcase
    endfunction

    function automatic int model_count();
        int own;
        if (m_ph == M_HG || m_ph == M_VG) begin
            own = (m_ph == M_HG) ? 0 : 1;
            if (m_el < T_MIN) return T_MIN - m_el;
            if ((m_pend[1 - own] || m_pend[2]) && m_el < T_MAX) return T_MAX - m_el;
            return 0;
        end
        if (m_ph == M_FLASH) return 0;
        return m_rem;
    endfunction

    // ---------------- scoreboard ----------------
    function automatic logic [6:0] obs_lamps();
        return {hr, hy, hg, vr, vy, vg, walk};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_model();
        check("lamps", 32'(obs_lamps()), 32'(model_lamps()));
        check("count", 32'(count), 32'(model_count()));
        check("pend", 32'({dbg.pend_h, dbg.pend_v, dbg.pend_p}),
              32'({m_pend[0], m_pend[1], m_pend[2]}));
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input bit h, input bit v, input bit p, input bit f, input bit c);
        req_h = h; req_v = v; ped_req = p; flash = f; clr = c;
        @(posedge clk);
        model_step(h, v, p, f, c);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
    endtask

    // Counts cycles while the selected lamp stays lit, holding the given inputs.
    task automatic measure(input int idx, input bit h, input bit v, input bit p, output int len);
        logic [6:0] o;
        len = 0;
        o = obs_lamps();
        while (o[idx] === 1'b1 && len < 300) begin
            len++;
            cycle(h, v, p, 0, 0);
            o = obs_lamps();
        end
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        bit rh, rv, rf;
        model_reset();

        // Reset, then rest on H green
        do_reset();
        check("rst_hr_vr", 32'({hr, vr, hg, vg, walk}), 32'(5'b11000));
        check("rst_count", 32'(count), 32'd1);
        check("rst_pend", 32'({dbg.pend_h, dbg.pend_v, dbg.pend_p}), 32'd0);
        for (int i = 0; i < 55; i++) cycle(0, 0, 0, 0, 0);
        check("rest_hg", 32'(hg), 32'd1);
        check("rest_count", 32'(count), 32'd0);

        // V pulse at green start with req_h low
        do_reset();
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        measure(L_HG, 0, 0, 0, len);
        check("hg_len_min", 32'(len + 1), 32'(T_MIN));
        measure(L_HY, 0, 0, 0, len);
        check("hy_len", 32'(len), 32'(T_Y));
        check("clear_allred", 32'(obs_lamps()), 32'(7'b100_100_0));
        cycle(0, 0, 0, 0, 0);
        check("vg_after_clear", 32'(vg), 32'd1);
        check("pend_v_clr", 32'(dbg.pend_v), 32'd0);

        // req_h held: green runs to max
        do_reset();
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        measure(L_HG, 1, 0, 0, len);
        check("hg_len_max", 32'(len + 1), 32'(T_MAX));
        check("hy_after_max", 32'(hy), 32'd1);

        // V and ped both waiting: V, then walk, then H rest
        do_reset();
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0);
        measure(L_HG, 0, 0, 0, len);
        measure(L_HY, 0, 0, 0, len);
        cycle(0, 0, 0, 0, 0);
        check("vg_first", 32'(vg), 32'd1);
        check("pend_p_kept", 32'(dbg.pend_p), 32'd1);
        measure(L_VG, 0, 0, 0, len);
        check("vg_len", 32'(len), 32'(T_MIN));
        measure(L_VY, 0, 0, 0, len);
        check("vy_len", 32'(len), 32'(T_Y));
        cycle(0, 0, 0, 0, 0);
        measure(L_WALK, 0, 0, 0, len);
        check("walk_len", 32'(len), 32'(T_WK));
        check("walk_clear", 32'(obs_lamps()), 32'(7'b100_100_0));
        cycle(0, 0, 0, 0, 0);
        check("h_after_walk", 32'(hg), 32'd1);

        // clr in the second yellow cycle
        do_reset();
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        measure(L_HG, 0, 0, 0, len);
        cycle(0, 0, 0, 0, 0);
        check("hy2_pend_v", 32'(dbg.pend_v), 32'd1);
        cycle(0, 0, 0, 0, 1);
        check("clr_mid_yellow", 32'(obs_lamps()), 32'(7'b100_100_0));
        check("clr_count", 32'(count), 32'd1);
        check("clr_pend", 32'({dbg.pend_h, dbg.pend_v, dbg.pend_p}), 32'd0);

`ifdef TL_SCHED_FLASH_EN
        // Flash during V green
        do_reset();
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        measure(L_HG, 0, 0, 0, len);
        measure(L_HY, 0, 0, 0, len);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        check("flash_on", 32'({hy, vy, hr, vr}), 32'(4'b1100));
        cycle(0, 0, 0, 1, 0);
        check("flash_toggle", 32'({hy, vy}), 32'd0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);
        check("flash_clear", 32'(obs_lamps()), 32'(7'b100_100_0));
        cycle(0, 0, 0, 0, 0);
        check("flash_to_h", 32'(hg), 32'd1);
`endif

        // Random traffic against the model
        do_reset();
        rh = 0; rv = 0; rf = 0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 9) == 0) rh = !rh;
            if ($urandom_range(0, 9) == 0) rv = !rv;
            if (FLASH_EN && $urandom_range(0, 59) == 0) rf = !rf;
            cycle(rh, rv, $urandom_range(0, 29) == 0, rf, $urandom_range(0, 299) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tl_phase_scheduler.md
# tl_phase_scheduler

Demand-actuated phase scheduler for a two-approach intersection with a pedestrian crossing. It shares the right-of-way among three requesters: the horizontal approach, the vertical approach and the pedestrian walk phase. Grants rotate round-robin, with min/max green, yellow and all-red clearance timing. It drives the six lamp outputs, a walk lamp and a countdown, and sits directly above the lamp drivers and the countdown display.

## Interface
- T_MIN_GREEN, 5: minimum green duration, in clk cycles.
- T_MAX_GREEN, 20: maximum green duration while a competing request is pending (must be ≥ T_MIN_GREEN).
- T_YELLOW, 3: yellow duration.
- T_ALL_RED, 1: all-red clearance after every yellow and after walk.
- T_WALK, 6: pedestrian walk duration.
- All parameters are 1..255.

Ports:
- clk  in  1  phase tick; one cycle equals one time unit.
- clr  in  1  reset, synchronous, active-high.
- req_h  in  1  horizontal vehicle presence, level.
- req_v  in  1  vertical vehicle presence, level.
- ped_req  in  1  pedestrian button; any high cycle latches a request.
- flash  in  1  flashing-yellow override; exists only with TL_SCHED_FLASH_EN.
- hr, hy, hg, vr, vy, vg  out  1 each  lamps.
- walk  out  1  pedestrian walk lamp.
- count  out  8  remaining cycles of the current timed interval.

## Operation
- States: INIT (all-red), H_GREEN, H_YELLOW, V_GREEN, V_YELLOW, PED_WALK, CLEAR (all-red), FLASH (macro only).
- Lamps per state:
  - H_GREEN: hg, vr.
  - H_YELLOW: hy, vr.
  - V_GREEN: hr, vg.
  - V_YELLOW: hr, vy.
  - INIT, CLEAR, PED_WALK: hr, vr. walk=1 only in PED_WALK.
- Pending flags pend_h, pend_v, pend_p:
  - Set on req_h, req_v or ped_req high in any cycle where that requester is not currently granted.
  - Cleared on entry to the granted phase.
  - A request asserted during its own green or walk is not latched.
- Green termination:
  - Green never ends before T_MIN_GREEN cycles.
  - After the minimum, green ends when any competing pend flag is set AND either the own presence input is low or T_MAX_GREEN cycles have elapsed.
  - With no competing demand, green rests indefinitely.
- Sequencing:
  - GREEN → YELLOW (T_YELLOW) → CLEAR (T_ALL_RED) → arbitrate.
  - PED_WALK (T_WALK) → CLEAR → arbitrate.
- Arbitration at CLEAR/INIT exit:
  - Fixed rotation H→V→PED→H, starting after last_served.
  - Grant the first pending requester.
  - If none is pending, grant H (rest on H green).
- Reset: state INIT, count=T_ALL_RED, hr=vr=1, other lamps 0, walk=0, all pend flags 0, last_served=PED (so H has first priority).
- count:
  - Timed states load the duration on entry and decrement each cycle.
  - Green shows remaining min-green cycles, then remaining max-green cycles while competing demand is pending, otherwise 0.
- Elapsed-green counter is 8 bits and saturates at 255.

## Timing
- Moore outputs, registered from the state register. Lamps change on the edge where the state changes.
- Input sampled at edge N affects pend and the state decision at edge N; the earliest visible lamp change is after edge N.
- Timed states last exactly their parameter in cycles. The transition occurs on the edge where count==1.
- clr has priority over all inputs, including mid-yellow and mid-walk. It forces INIT on the next edge.
- A simultaneous request and phase entry for the same requester: entry wins and the flag stays clear.

## Configuration
- TL_SCHED_FLASH_EN defined:
  - The flash port exists.
  - flash=1 forces FLASH on the next edge from any state except INIT. In FLASH, hy=vy toggle every cycle starting at 1, all other lamps and walk are 0, count=0, and pend flags are cleared.
  - On flash falling, go to CLEAR (T_ALL_RED), then normal arbitration.
- Undefined: no flash port and no FLASH state.

## Structure
- Shared package tl_sched_pkg holds:
  - State enum.
  - 6-bit lamp encodings {hr,hy,hg,vr,vy,vg}.
  - Requester id type (H/V/PED).
  - Default timing constants.
- Natural sub-module: tl_phase_timer, an 8-bit load/decrement timer with a done output at count==1.

## Test plan
- clr high 2 cycles, no requests → hr=vr=1, count=1 for one cycle, then H green held 50 cycles with count=0.
- H green resting, req_v pulse for 1 cycle, req_h low → hg lasts 5 cycles total, then hy 3, all-red 1, then vg with pend_v cleared.
- req_h held high, req_v pulsed at green start → hg lasts exactly 20 cycles, then yellow.
- During H green, ped_req and req_v both pulsed → V green first, then yellow/clear, then walk=1 for 6 cycles, then all-red 1, then H (H wins if pending, else H rest).
- clr asserted in the second cycle of H_YELLOW → next edge INIT, pend flags 0, count=1.
- (TL_SCHED_FLASH_EN) flash high during V green → next cycle hy=vy=1, toggling each cycle. Flash low → 1 cycle all-red, then H green.
